// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: handshake and byte-serial bus bundle for mem_port_arbiter
//  master : arbiter side (drives mem_dout/mem_a/mem_wr, grants, valids, read data, busy)
//  slave  : environment side (ICache, LSB, RAM/IO, pipeline control)
interface mem_port_arbiter_if #(
  parameter int INST_BYTES = 4
);
  logic                    rdy_in;
  logic                    clear_in;
  logic                    io_buffer_full;
  logic [7:0]              mem_din;
  logic [7:0]              mem_dout;
  logic [31:0]             mem_a;
  logic                    mem_wr;
  logic                    inst_req_in;
  logic [31:0]             inst_addr_in;
  logic                    inst_gnt_out;
  logic                    inst_valid_out;
  logic [8*INST_BYTES-1:0] inst_data_out;
  logic                    data_req_in;
  logic                    data_we_in;
  logic [1:0]              data_size_in;
  logic [31:0]             data_addr_in;
  logic [31:0]             data_wdata_in;
  logic                    data_gnt_out;
  logic                    data_valid_out;
  logic [31:0]             data_rdata_out;
  logic                    busy_out;
  modport master (
    input  rdy_in, clear_in, io_buffer_full, mem_din,
    input  inst_req_in, inst_addr_in,
    input  data_req_in, data_we_in, data_size_in, data_addr_in, data_wdata_in,
    output mem_dout, mem_a, mem_wr,
    output inst_gnt_out, inst_valid_out, inst_data_out,
    output data_gnt_out, data_valid_out, data_rdata_out, busy_out
  );
  modport slave (
    output rdy_in, clear_in, io_buffer_full, mem_din,
    output inst_req_in, inst_addr_in,
    output data_req_in, data_we_in, data_size_in, data_addr_in, data_wdata_in,
    input  mem_dout, mem_a, mem_wr,
    input  inst_gnt_out, inst_valid_out, inst_data_out,
    input  data_gnt_out, data_valid_out, data_rdata_out, busy_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: owns the byte-serial RAM/IO port, arbitrates ICache refills against LSB
//  loads/stores and sequences multi-byte transfers one byte per cycle.
//  clk_in  : system clock
//  rst_in  : synchronous active-high reset
//  m       : mem_port_arbiter_if.master (rdy/clear, mem_* bus, inst and data request channels, busy)
//  Optional MEM_ARB_STARVE_GUARD_EN: after STARVE_LIMIT data grants made while a refill waits,
//  the refill is granted ahead of data.
module mem_port_arbiter #(
  parameter int INST_BYTES   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk_in,
  input logic rst_in,
  mem_port_arbiter_if.master m
);
  typedef enum logic [1:0] {IDLE, XFER, TAIL} state_t;
  state_t                  state;
  logic [31:0]             base, dat, nxt, data_q, addr;
  logic [8*INST_BYTES-1:0] inst_q;
  logic [2:0]              k, n;
  logic [1:0]              kp;
  logic                    we, is_inst, inst_v, data_v;
  logic                    can_gnt, inst_first, d_gnt, i_gnt, throttle, last;
  assign can_gnt  = !rst_in && m.rdy_in && !m.clear_in && state == IDLE;
  assign d_gnt    = can_gnt && m.data_req_in && !inst_first;
  assign i_gnt    = can_gnt && m.inst_req_in && !d_gnt;
  assign addr     = base + 32'(k);
  assign throttle = m.io_buffer_full && addr[17:16] == 2'b11;
  assign last     = k == n - 3'd1;
  // read bytes arrive one cycle behind their address, so the byte landing now belongs to k-1
  assign kp       = 2'(k - 3'd1);
  always_comb begin
    nxt = dat;
    nxt[{kp, 3'b000} +: 8] = m.mem_din;
  end
  assign m.inst_gnt_out   = i_gnt;
  assign m.data_gnt_out   = d_gnt;
  assign m.busy_out       = state != IDLE;
  assign m.mem_a          = state == XFER ? addr : 32'h0;
  assign m.mem_wr         = state == XFER && we && !throttle && m.rdy_in;
  assign m.mem_dout       = (state == XFER && we) ? dat[{k[1:0], 3'b000} +: 8] : 8'h00;
  assign m.inst_valid_out = inst_v;
  assign m.inst_data_out  = inst_q;
  assign m.data_valid_out = data_v;
  assign m.data_rdata_out = data_q;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 2);
  logic [CW-1:0] starve;
  assign inst_first = m.inst_req_in && starve == CW'(STARVE_LIMIT);
  always_ff @(posedge clk_in) begin
    if (rst_in) starve <= '0;
    else if (m.rdy_in) starve <= (i_gnt || m.clear_in) ? '0 : (d_gnt && m.inst_req_in) ? starve + 1'b1 : starve;
  end
`else
  // guard disabled: data always has priority
  assign inst_first = STARVE_LIMIT < 0;
`endif
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= IDLE;
      base    <= '0;
      dat     <= '0;
      k       <= '0;
      n       <= '0;
      we      <= 1'b0;
      is_inst <= 1'b0;
      inst_v  <= 1'b0;
      data_v  <= 1'b0;
      inst_q  <= '0;
      data_q  <= '0;
    end else if (m.rdy_in) begin
      inst_v <= 1'b0;
      data_v <= 1'b0;
      case (state)
        IDLE: if (d_gnt || i_gnt) begin
          state   <= XFER;
          k       <= '0;
          is_inst <= i_gnt;
          we      <= d_gnt && m.data_we_in;
          base    <= i_gnt ? m.inst_addr_in : m.data_addr_in;
          n       <= i_gnt ? 3'(INST_BYTES) : m.data_size_in == 2'd0 ? 3'd1 : m.data_size_in == 2'd1 ? 3'd2 : 3'd4;
          // loads start from zero so bytes above the access size read back as zero
          dat     <= (d_gnt && m.data_we_in) ? m.data_wdata_in : '0;
        end
        XFER: if (we) begin
          if (!throttle) begin
            k <= k + 3'd1;
            if (last) begin
              state  <= IDLE;
              data_v <= 1'b1;
            end
          end
        end else if (m.clear_in) state <= IDLE;
        else begin
          if (k != 3'd0) dat <= nxt;
          k <= k + 3'd1;
          if (last) state <= TAIL;
        end
        TAIL: begin
          state <= IDLE;
          if (!m.clear_in) begin
            inst_v <= is_inst;
            data_v <= !is_inst;
            if (is_inst) inst_q <= nxt[8*INST_BYTES-1:0];
            else data_q <= nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
